ghost_mode_scheduler: RTL and testbench
=======================================

// Module: ghost_mode_scheduler
// PURPOSE
//  Sequences global ghost behaviour mode (SCATTER/CHASE/FRIGHT) from a per-frame tick, following a fixed
//  scatter/chase phase table. Handles power-pellet fright windows with end-of-fright flashing. Issues a one-cycle
//  reverse-direction request on every mode change. Sits beside the pacman mover; drives all ghost movers and the ghost sprite selector.
// PARAMETERS
//  SCAT_A     420   frames, scatter phases 0 and 2
//  SCAT_B     300   frames, scatter phases 4 and 6
//  CHASE_LEN  1200  frames, chase phases 1, 3 and 5 (phase 7 = chase, unbounded)
//  FRIGHT_LEN 360   frames in FRIGHT per pellet
//  FLASH_LEN  120   final FRIGHT frames during which fright_flash toggles
//  FLASH_HALF 8     frames per flash half-period
// PORTS
//  Clk          in   1   system clock (50 MHz)
//  Reset_n      in   1   asynchronous active-low reset
//  frame_tick   in   1   one-Clk pulse per video frame; all timers advance only on it
//  game_start   in   1   pulse: begin/resume play from phase 0
//  pellet_eaten in   1   pulse: power pellet consumed
//  pacman_dead  in   1   pulse: freeze scheduling
//  mode         out  2   0 SCATTER, 1 CHASE, 2 FRIGHT, 3 FROZEN
//  fright_flash out  1   1 = draw flashing (white) fright sprite
//  reverse_req  out  1   one-Clk pulse: ghosts reverse direction
//  phase_idx    out  3   current scatter/chase phase 0..7
// BEHAVIOUR
//  Reset: state FROZEN, mode=3, phase_idx=0, phase/fright timers=0, fright_flash=0, reverse_req=0.
//  States: FROZEN, SCATTER, CHASE, FRIGHT. mode is a registered copy of state; 1-cycle latency from the causing event.
//  FROZEN: timers hold. game_start -> SCATTER, phase_idx=0, phase timer=0, no reverse_req.
//  SCATTER/CHASE: on frame_tick the phase timer increments.
//   - Phase timer reaching the phase length (SCAT_A/CHASE_LEN/SCAT_A/CHASE_LEN/SCAT_B/CHASE_LEN/SCAT_B) on a tick:
//     phase_idx+1, timer=0, flip SCATTER<->CHASE, reverse_req pulse.
//   - Phase 7: timer saturates, no further transition.
//  pellet_eaten in SCATTER/CHASE: save the current mode, go to FRIGHT, fright timer=0, reverse_req pulse.
//   - The phase timer is paused (not reset) for the whole fright window.
//  FRIGHT: fright timer increments per tick.
//   - fright_flash=1 when timer >= FRIGHT_LEN-FLASH_LEN and (timer-(FRIGHT_LEN-FLASH_LEN))/FLASH_HALF is even; else 0.
//   - On timer==FRIGHT_LEN-1 plus tick: return to the saved mode, fright_flash=0, no reverse_req.
//   - pellet_eaten in FRIGHT: fright timer=0, flash clears, no reverse_req.
//  pacman_dead in any state -> FROZEN: fright aborted, fright_flash=0, phase_idx and phase timer retained.
//   - game_start from FROZEN always restarts at phase 0.
//  Simultaneous events, priority: pacman_dead > game_start > pellet_eaten > timer expiry.
//   - Exception: pellet_eaten on the expiry tick still advances the phase, then enters FRIGHT; the saved mode is the new mode; one reverse_req only.
//  game_start outside FROZEN: restart at SCATTER phase 0, no reverse_req.
//  Widths: phase timer 11 b, fright timer 9 b; no wrap (compare-equal then clear).
//  Reset_n asserted mid-fright: immediate return to reset values.
// STRUCTURE
//  pacman_pkg: typedef enum logic [1:0] ghost_mode_t {SCATTER, CHASE, FRIGHT, FROZEN}; phase-length lookup function.
//  Sub-module frame_timer: tick counter with clear/enable/terminal-count output, instantiated twice (phase, fright).
//  Top: state FSM, saved-mode register, flash decode, reverse pulse register.
// TESTING (frame_tick tied high unless noted)
//  1. Reset_n low->high, game_start -> mode=0 next cycle; at tick 420 mode=1, phase_idx=1, one reverse_req.
//  2. Run to phase 7 -> mode=1 held for 5000 ticks, no reverse_req, phase_idx=7.
//  3. pellet_eaten at phase 1 tick 100 -> mode=2 plus reverse_req; flash first high at fright tick 240, toggling every 8;
//     at 360 mode=1, phase timer resumes at 100.
//  4. pellet_eaten again at fright tick 300 -> fright extends to 660 total ticks, no second reverse_req.
//  5. pacman_dead during FRIGHT -> mode=3, flash=0, timers hold; game_start -> mode=0, phase_idx=0.
//  6. pellet_eaten on the scatter expiry tick -> phase_idx=1, mode=2, saved mode CHASE, exactly one reverse_req; frame_tick gaps pause everything.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and frame-count constants for the ghost mode scheduler.
// Holds the ghost mode enum and the scatter/chase phase-length lookup.
package pacman_pkg;

    typedef enum logic [1:0] {
        SCATTER = 2'd0,
        CHASE   = 2'd1,
        FRIGHT  = 2'd2,
        FROZEN  = 2'd3
    } ghost_mode_t;

    localparam int unsigned SCAT_A_DEF     = 420;
    localparam int unsigned SCAT_B_DEF     = 300;
    localparam int unsigned CHASE_LEN_DEF  = 1200;
    localparam int unsigned FRIGHT_LEN_DEF = 360;
    localparam int unsigned FLASH_LEN_DEF  = 120;
    localparam int unsigned FLASH_HALF_DEF = 8;

    localparam int unsigned PH_W = 11;
    localparam int unsigned FR_W = 9;

    // Frames spent in a given phase; phase 7 is unbounded and returns 0.
    function automatic logic [PH_W-1:0] phase_len(
        input logic [2:0]  ph,
        input int unsigned sa,
        input int unsigned sb,
        input int unsigned cl
    );
        logic [PH_W-1:0] len;
        case (ph)
            3'd0, 3'd2:       len = PH_W'(sa);
            3'd4, 3'd6:       len = PH_W'(sb);
            3'd1, 3'd3, 3'd5: len = PH_W'(cl);
            default:          len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Saturating frame counter with synchronous clear and terminal-count flag.
// Ports: clk_i/rst_ni, clr_i, en_i, last_i (terminal value), cnt_o, tc_o.
module frame_timer #(
    parameter int unsigned W = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: scatter/chase phase table, fright windows
// with end-of-fright flashing, and a reverse pulse on every mode change.
// Ports: Clk, Reset_n, frame_tick, game_start, pellet_eaten, pacman_dead
// in; mode[1:0], fright_flash, reverse_req, phase_idx[2:0] out.
module ghost_mode_scheduler
    import pacman_pkg::*;
#(
    parameter int unsigned SCAT_A     = SCAT_A_DEF,
    parameter int unsigned SCAT_B     = SCAT_B_DEF,
    parameter int unsigned CHASE_LEN  = CHASE_LEN_DEF,
    parameter int unsigned FRIGHT_LEN = FRIGHT_LEN_DEF,
    parameter int unsigned FLASH_LEN  = FLASH_LEN_DEF,
    parameter int unsigned FLASH_HALF = FLASH_HALF_DEF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       pellet_eaten,
    input  logic       pacman_dead,
    output logic [1:0] mode,
    output logic       fright_flash,
    output logic       reverse_req,
    output logic [2:0] phase_idx
);

    localparam int unsigned FLASH_START = FRIGHT_LEN - FLASH_LEN;

    ghost_mode_t state_q, state_d;
    ghost_mode_t saved_q, saved_d;
    ghost_mode_t base;
    logic [2:0]  phase_q, phase_d;
    logic [2:0]  nxt_phase;
    logic        rev_q, rev_d;

    logic            ph_clr, ph_en, ph_tc, ph_exp;
    logic [PH_W-1:0] ph_cnt, ph_last;
    logic            fr_clr, fr_en, fr_tc, fr_exp;
    logic [FR_W-1:0] fr_cnt, fr_last;
    logic [FR_W-1:0] fl_off;
    logic            fl_even;

    // Terminal value is length-1: the expiring tick is the length-th one.
    assign ph_last = phase_len(phase_q, SCAT_A, SCAT_B, CHASE_LEN)
                   - PH_W'(1);
    assign fr_last = FR_W'(FRIGHT_LEN - 1);

    // Phase 7 never expires; its timer just saturates.
    assign ph_exp = frame_tick && ph_tc && (phase_q != 3'd7);
    assign fr_exp = frame_tick && fr_tc;

    assign nxt_phase = phase_q + 3'd1;

    frame_timer #(.W(PH_W)) u_phase_tmr (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .clr_i  (ph_clr),
        .en_i   (ph_en),
        .last_i (ph_last),
        .cnt_o  (ph_cnt),
        .tc_o   (ph_tc)
    );

    frame_timer #(.W(FR_W)) u_fright_tmr (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .clr_i  (fr_clr),
        .en_i   (fr_en),
        .last_i (fr_last),
        .cnt_o  (fr_cnt),
        .tc_o   (fr_tc)
    );

    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        phase_d = phase_q;
        rev_d   = 1'b0;
        ph_clr  = 1'b0;
        ph_en   = 1'b0;
        fr_clr  = 1'b0;
        fr_en   = 1'b0;
        base    = state_q;
        if (pacman_dead) begin
            state_d = FROZEN;
            fr_clr  = 1'b1;
        end else if (game_start) begin
            state_d = SCATTER;
            phase_d = '0;
            ph_clr  = 1'b1;
            fr_clr  = 1'b1;
        end else begin
            unique case (state_q)
                SCATTER, CHASE: begin
                    if (ph_exp) begin
                        phase_d = nxt_phase;
                        ph_clr  = 1'b1;
                        rev_d   = 1'b1;
                        base    = nxt_phase[0] ? CHASE : SCATTER;
                    end else begin
                        // Pellet cycle pauses the phase timer too.
                        ph_en = frame_tick && !pellet_eaten;
                    end
                    if (pellet_eaten) begin
                        // On an expiry tick the new mode is saved.
                        state_d = FRIGHT;
                        saved_d = base;
                        fr_clr  = 1'b1;
                        rev_d   = 1'b1;
                    end else begin
                        state_d = base;
                    end
                end
                FRIGHT: begin
                    if (pellet_eaten) begin
                        fr_clr = 1'b1;
                    end else if (fr_exp) begin
                        state_d = saved_q;
                        fr_clr  = 1'b1;
                    end else begin
                        fr_en = frame_tick;
                    end
                end
                FROZEN: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= FROZEN;
            saved_q <= SCATTER;
            phase_q <= '0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            phase_q <= phase_d;
            rev_q   <= rev_d;
        end
    end

    // Flash in alternating FLASH_HALF slots, starting lit.
    assign fl_off  = fr_cnt - FR_W'(FLASH_START);
    assign fl_even = (((fl_off / FR_W'(FLASH_HALF)) % FR_W'(2)) == '0);

    assign fright_flash = (state_q == FRIGHT)
                       && (fr_cnt >= FR_W'(FLASH_START))
                       && fl_even;

    assign mode        = state_q;
    assign reverse_req = rev_q;
    assign phase_idx   = phase_q;

    // Phase count is only observed through its terminal flag.
    logic unused_ph;
    assign unused_ph = ^ph_cnt;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed self-checking bench for ghost_mode_scheduler.
// Inputs change just after negedge; outputs sampled at negedge.
module tb_ghost_mode_scheduler;

    logic       Clk;
    logic       Reset_n;
    logic       frame_tick;
    logic       game_start;
    logic       pellet_eaten;
    logic       pacman_dead;
    logic [1:0] mode;
    logic       fright_flash;
    logic       reverse_req;
    logic [2:0] phase_idx;

    int errors;
    int checks;
    int rev_cnt;

    ghost_mode_scheduler dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .game_start   (game_start),
        .pellet_eaten (pellet_eaten),
        .pacman_dead  (pacman_dead),
        .mode         (mode),
        .fright_flash (fright_flash),
        .reverse_req  (reverse_req),
        .phase_idx    (phase_idx)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (reverse_req) rev_cnt++;
        end
    endtask

    task automatic start_pulse();
        game_start = 1'b1;
        step(1);
        game_start = 1'b0;
    endtask

    task automatic pellet_pulse();
        pellet_eaten = 1'b1;
        step(1);
        pellet_eaten = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n      = 1'b0;
        frame_tick   = 1'b1;
        game_start   = 1'b0;
        pellet_eaten = 1'b0;
        pacman_dead  = 1'b0;
        rev_cnt      = 0;
        step(3);
        checks++;
        if (mode !== 2'd3 || phase_idx !== 3'd0
            || fright_flash !== 1'b0 || reverse_req !== 1'b0) begin
            errors++;
            $display("FAIL reset: mode=%0d ph=%0d fl=%b rv=%b exp 3 0 0 0",
                     mode, phase_idx, fright_flash, reverse_req);
        end
        Reset_n = 1'b1;
        step(5);
        checks++;
        if (mode !== 2'd3) begin
            errors++;
            $display("FAIL frozen_hold: mode=%0d exp 3", mode);
        end
    endtask

    task automatic test_first_phase();
        rev_cnt = 0;
        start_pulse();
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd0 || rev_cnt !== 0) begin
            errors++;
            $display("FAIL start: mode=%0d ph=%0d rv=%0d exp 0 0 0",
                     mode, phase_idx, rev_cnt);
        end
        step(419);
        checks++;
        if (mode !== 2'd0) begin
            errors++;
            $display("FAIL tick419: mode=%0d exp 0", mode);
        end
        step(1);
        checks++;
        if (mode !== 2'd1 || phase_idx !== 3'd1 || rev_cnt !== 1) begin
            errors++;
            $display("FAIL tick420: mode=%0d ph=%0d rv=%0d exp 1 1 1",
                     mode, phase_idx, rev_cnt);
        end
        step(1);
        checks++;
        if (reverse_req !== 1'b0 || rev_cnt !== 1) begin
            errors++;
            $display("FAIL rev_width: rv=%b cnt=%0d exp 0 1",
                     reverse_req, rev_cnt);
        end
    endtask

    task automatic test_phase7();
        int n;
        n = 1;
        rev_cnt = 0;
        while (phase_idx != 3'd7 && n < 6000) begin
            step(1);
            n++;
        end
        // Phases 1..6 total 4620 frames after phase 1 began.
        checks++;
        if (n !== 4620 || rev_cnt !== 6) begin
            errors++;
            $display("FAIL to_phase7: cycles=%0d revs=%0d exp 4620 6",
                     n, rev_cnt);
        end
        rev_cnt = 0;
        step(5000);
        checks++;
        if (mode !== 2'd1 || phase_idx !== 3'd7 || rev_cnt !== 0) begin
            errors++;
            $display("FAIL phase7_hold: mode=%0d ph=%0d rv=%0d exp 1 7 0",
                     mode, phase_idx, rev_cnt);
        end
    endtask

    task automatic test_fright();
        rev_cnt = 0;
        start_pulse();
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd0 || rev_cnt !== 0) begin
            errors++;
            $display("FAIL restart: mode=%0d ph=%0d rv=%0d exp 0 0 0",
                     mode, phase_idx, rev_cnt);
        end
        step(420);
        step(100);
        rev_cnt = 0;
        pellet_pulse();
        checks++;
        if (mode !== 2'd2 || rev_cnt !== 1 || fright_flash !== 1'b0) begin
            errors++;
            $display("FAIL fright_in: mode=%0d rv=%0d fl=%b exp 2 1 0",
                     mode, rev_cnt, fright_flash);
        end
        step(239);
        checks++;
        if (fright_flash !== 1'b0) begin
            errors++;
            $display("FAIL flash239: got %b exp 0", fright_flash);
        end
        step(1);
        checks++;
        if (fright_flash !== 1'b1) begin
            errors++;
            $display("FAIL flash240: got %b exp 1", fright_flash);
        end
        step(7);
        checks++;
        if (fright_flash !== 1'b1) begin
            errors++;
            $display("FAIL flash247: got %b exp 1", fright_flash);
        end
        step(1);
        checks++;
        if (fright_flash !== 1'b0) begin
            errors++;
            $display("FAIL flash248: got %b exp 0", fright_flash);
        end
        step(8);
        checks++;
        if (fright_flash !== 1'b1) begin
            errors++;
            $display("FAIL flash256: got %b exp 1", fright_flash);
        end
        step(103);
        checks++;
        if (mode !== 2'd2 || fright_flash !== 1'b1) begin
            errors++;
            $display("FAIL fright359: mode=%0d fl=%b exp 2 1",
                     mode, fright_flash);
        end
        step(1);
        checks++;
        if (mode !== 2'd1 || fright_flash !== 1'b0 || rev_cnt !== 1) begin
            errors++;
            $display("FAIL fright_out: mode=%0d fl=%b rv=%0d exp 1 0 1",
                     mode, fright_flash, rev_cnt);
        end
        // Phase timer resumed at 100 of 1200.
        step(1099);
        checks++;
        if (mode !== 2'd1 || phase_idx !== 3'd1) begin
            errors++;
            $display("FAIL resume1299: mode=%0d ph=%0d exp 1 1",
                     mode, phase_idx);
        end
        step(1);
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd2) begin
            errors++;
            $display("FAIL resume1300: mode=%0d ph=%0d exp 0 2",
                     mode, phase_idx);
        end
    endtask

    task automatic test_fright_extend();
        rev_cnt = 0;
        pellet_pulse();
        step(300);
        pellet_pulse();
        checks++;
        if (mode !== 2'd2 || rev_cnt !== 1 || fright_flash !== 1'b0) begin
            errors++;
            $display("FAIL extend: mode=%0d rv=%0d fl=%b exp 2 1 0",
                     mode, rev_cnt, fright_flash);
        end
        step(359);
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL extend659: mode=%0d exp 2", mode);
        end
        step(1);
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd2 || rev_cnt !== 1) begin
            errors++;
            $display("FAIL extend660: mode=%0d ph=%0d rv=%0d exp 0 2 1",
                     mode, phase_idx, rev_cnt);
        end
    endtask

    task automatic test_dead();
        pellet_pulse();
        step(245);
        checks++;
        if (fright_flash !== 1'b1) begin
            errors++;
            $display("FAIL pre_dead_flash: got %b exp 1", fright_flash);
        end
        rev_cnt = 0;
        pacman_dead = 1'b1;
        step(1);
        pacman_dead = 1'b0;
        checks++;
        if (mode !== 2'd3 || fright_flash !== 1'b0 || phase_idx !== 3'd2) begin
            errors++;
            $display("FAIL dead: mode=%0d fl=%b ph=%0d exp 3 0 2",
                     mode, fright_flash, phase_idx);
        end
        step(50);
        checks++;
        if (mode !== 2'd3 || phase_idx !== 3'd2 || rev_cnt !== 0) begin
            errors++;
            $display("FAIL dead_hold: mode=%0d ph=%0d rv=%0d exp 3 2 0",
                     mode, phase_idx, rev_cnt);
        end
        start_pulse();
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd0 || rev_cnt !== 0) begin
            errors++;
            $display("FAIL dead_restart: mode=%0d ph=%0d rv=%0d exp 0 0 0",
                     mode, phase_idx, rev_cnt);
        end
    endtask

    task automatic test_pellet_on_expiry();
        step(419);
        rev_cnt = 0;
        pellet_pulse();
        checks++;
        if (mode !== 2'd2 || phase_idx !== 3'd1 || rev_cnt !== 1) begin
            errors++;
            $display("FAIL exp_pellet: mode=%0d ph=%0d rv=%0d exp 2 1 1",
                     mode, phase_idx, rev_cnt);
        end
        frame_tick = 1'b0;
        step(100);
        frame_tick = 1'b1;
        step(359);
        checks++;
        if (mode !== 2'd2) begin
            errors++;
            $display("FAIL gap_fright: mode=%0d exp 2", mode);
        end
        step(1);
        checks++;
        if (mode !== 2'd1 || rev_cnt !== 1) begin
            errors++;
            $display("FAIL saved_chase: mode=%0d rv=%0d exp 1 1",
                     mode, rev_cnt);
        end
        step(600);
        frame_tick = 1'b0;
        step(77);
        frame_tick = 1'b1;
        step(599);
        checks++;
        if (mode !== 2'd1 || phase_idx !== 3'd1) begin
            errors++;
            $display("FAIL gap_chase: mode=%0d ph=%0d exp 1 1",
                     mode, phase_idx);
        end
        step(1);
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd2 || rev_cnt !== 2) begin
            errors++;
            $display("FAIL gap_expire: mode=%0d ph=%0d rv=%0d exp 0 2 2",
                     mode, phase_idx, rev_cnt);
        end
    endtask

    task automatic test_back_to_back();
        // game_start outranks pellet_eaten on the same cycle.
        rev_cnt = 0;
        game_start   = 1'b1;
        pellet_eaten = 1'b1;
        step(1);
        game_start   = 1'b0;
        pellet_eaten = 1'b0;
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd0 || rev_cnt !== 0) begin
            errors++;
            $display("FAIL start_vs_pellet: mode=%0d ph=%0d rv=%0d exp 0 0 0",
                     mode, phase_idx, rev_cnt);
        end
        // pacman_dead outranks game_start.
        game_start  = 1'b1;
        pacman_dead = 1'b1;
        step(1);
        game_start  = 1'b0;
        pacman_dead = 1'b0;
        checks++;
        if (mode !== 2'd3) begin
            errors++;
            $display("FAIL dead_vs_start: mode=%0d exp 3", mode);
        end
    endtask

    task automatic test_reset_mid_fright();
        start_pulse();
        pellet_pulse();
        step(250);
        #3 Reset_n = 1'b0;
        #1;
        checks++;
        if (mode !== 2'd3 || phase_idx !== 3'd0
            || fright_flash !== 1'b0 || reverse_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: mode=%0d ph=%0d fl=%b rv=%b exp 3 0 0 0",
                     mode, phase_idx, fright_flash, reverse_req);
        end
        step(2);
        Reset_n = 1'b1;
        step(2);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_first_phase();
        test_phase7();
        test_fright();
        test_fright_extend();
        test_dead();
        test_pellet_on_expiry();
        test_back_to_back();
        test_reset_mid_fright();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
